// File: rtl/wb_flush_redirect_controller_if.sv
// Redirect handshake between the WB flush controller (master) and the IF stage (slave).
interface wb_flush_redirect_controller_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/wb_flush_redirect_controller.sv
// Sequences WB-raised pipeline flushes: squashes in-flight fetch responses, then hands the redirect to IF.
// Optional flush event counter enabled by defining FLUSH_PERF_COUNTER_EN.
module wb_flush_redirect_controller #(
    parameter int unsigned MAX_OUTSTANDING  = 2,
    parameter logic [31:0] REFILL_VECTOR    = 32'hbfc00200,
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hbfc00380
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_flush_pipe,
    input  logic        wb_exception_valid,
    input  logic        wb_eret_flush,
    input  logic        wb_tlb_write_flush,
    input  logic        wb_tlb_refill,
    input  logic [31:0] wb_program_count_plus4,
    input  logic [31:0] cp0_epc,
    input  logic        inst_req_fire,
    input  logic        inst_data_ok,
    output logic        flush_pipe,
    output logic        inst_resp_discard,
    wb_flush_redirect_controller_if.master redirect_if,
    output logic        busy,
    output logic [31:0] flush_count
);
    localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   redirect_pc_q;
    logic [31:0]   target;

    assign flush_pipe        = wb_flush_pipe;
    assign inst_resp_discard = inst_data_ok && (discard_q != '0);

    always_comb begin
        target = wb_program_count_plus4;
        if (wb_exception_valid)
            target = wb_tlb_refill ? REFILL_VECTOR : EXCEPTION_VECTOR;
        else if (wb_eret_flush)
            target = cp0_epc;
        else if (wb_tlb_write_flush)
            target = wb_program_count_plus4;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (inst_req_fire && !inst_data_ok)
            outstanding_d = outstanding_q + ONE;
        else if (!inst_req_fire && inst_data_ok)
            outstanding_d = outstanding_q - ONE;
    end

    // A beat arriving in the event cycle is still accepted, so it is excluded from the reload.
    always_comb begin
        discard_d = discard_q;
        if (wb_flush_pipe)
            discard_d = (inst_data_ok && outstanding_q != '0) ? outstanding_q - ONE : outstanding_q;
        else if (inst_resp_discard)
            discard_d = discard_q - ONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            discard_q     <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (wb_flush_pipe)
                redirect_pc_q <= target;
        end
    end

    // Leaving DRAIN on the next count lets the redirect rise right after the last squashed beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (wb_flush_pipe) state_d = DRAIN;
            DRAIN:    if (!wb_flush_pipe && discard_d == '0) state_d = REDIRECT;
            REDIRECT: begin
                if (wb_flush_pipe)
                    state_d = DRAIN;
                else if (redirect_if.redirect_ready)
                    state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        redirect_if.redirect_valid = (state_q == REDIRECT);
        redirect_if.redirect_pc    = redirect_pc_q;
        busy                       = (state_q != IDLE);
    end

`ifdef FLUSH_PERF_COUNTER_EN
    logic [31:0] flush_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            flush_count_q <= '0;
        else if (wb_flush_pipe)
            flush_count_q <= flush_count_q + 32'd1;
    end

    assign flush_count = flush_count_q;
`else
    assign flush_count = '0;
`endif

`ifndef SYNTHESIS
    a_outstanding_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(inst_req_fire && !inst_data_ok && outstanding_q == MAX_CNT))
        else $error("instruction-bus outstanding count exceeds MAX_OUTSTANDING");
    a_outstanding_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(inst_data_ok && !inst_req_fire && outstanding_q == '0))
        else $error("instruction-bus response with nothing outstanding");
    a_req_while_busy: assert property (@(posedge clock) disable iff (!reset_n)
        !(inst_req_fire && busy))
        else $error("IF issued a fetch before taking the redirect");
`endif
endmodule
